uart_instr_responder: RTL and testbench
=======================================

Name: uart_instr_responder

Overview:
- Host-side responder for the serial instruction-fetch link: the far end of the UART that the Bitty core's fetch unit initiates on.
- Byte-level block: sits behind a uart_module instance and exchanges whole bytes through the rx_done/rx_data and tx_en/tx_data/tx_done handshake.
- Holds a DEPTH x 16 instruction memory. Serves read requests (address in, two instruction bytes out) and write requests (address + two bytes in, ack byte out) used to preload programs.

Parameters:
DEPTH, 256, instruction words held; address byte is taken modulo DEPTH (DEPTH must be a power of two, <= 256)
TIMEOUT, 1000000, clk cycles allowed between bytes of one request before it is abandoned
ACK_BYTE, 8'hAA, byte returned after a completed write

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset (0 = reset)
rx_done  input  1  one-cycle pulse; rx_data valid in this cycle
rx_data  input  8  received byte
tx_done  input  1  one-cycle pulse; previous tx byte fully shifted out
tx_en  output  1  one-cycle pulse starting a byte transmission
tx_data  output  8  byte to send; held stable from tx_en until tx_done
busy  output  1  high whenever state != IDLE
err  output  1  one-cycle pulse on unknown command, timeout, or byte received while transmitting

Behaviour:
- Reset (asynchronous assert, synchronous release): state=IDLE, tx_en=0, tx_data=8'h00, busy=0, err=0, timeout counter=0. Memory contents are not cleared.
- Command bytes:
  - 8'h03 READ: followed by addr. Reply is mem[addr][15:8], then mem[addr][7:0].
  - 8'h01 WRITE: followed by addr, hi, lo. mem[addr] <= {hi,lo}, then reply ACK_BYTE.
  - Any other first byte: err pulse, stay in IDLE.
- States:
  - IDLE: on rx_done, decode the command.
  - GET_ADDR, GET_HI, GET_LO: each captures one byte on rx_done.
  - WRITE: one cycle; the memory write occurs here.
  - SEND_HI: tx_en=1 for one cycle, tx_data=hi. Then WAIT_HI.
  - WAIT_HI: wait for tx_done, then SEND_LO.
  - SEND_LO: tx_en=1 for one cycle, tx_data=lo. Then WAIT_LO.
  - WAIT_LO: on tx_done, go to IDLE.
  - SEND_ACK: tx_en=1 for one cycle, tx_data=ACK_BYTE. Then WAIT_ACK.
  - WAIT_ACK: on tx_done, go to IDLE.
- Latency:
  - READ: the addr rx_done cycle is cycle N. Memory is read synchronously in cycle N+1. tx_en for the hi byte is asserted in cycle N+2.
  - WRITE: the lo rx_done cycle is cycle N. The write happens in cycle N+1. tx_en for ACK_BYTE is asserted in cycle N+2.
- tx_data is held stable in the WAIT_* states; tx_en never asserts while in a WAIT_* state.
- Timeout:
  - In GET_* states, a counter increments every cycle and clears on rx_done.
  - When the counter reaches TIMEOUT-1: err pulse, go to IDLE, partial request discarded, no memory write.
  - WAIT_* states have no timeout.
- Byte during transmit: rx_done in SEND_*/WAIT_*/WRITE is dropped and produces an err pulse; the transmission continues unaffected.
- Simultaneous tx_done and rx_done in WAIT_LO/WAIT_ACK: the state goes to IDLE, the byte is dropped, and err pulses (the byte arrived while still transmitting).
- Address wrap: addr >= DEPTH uses addr[log2(DEPTH)-1:0].
- Reset mid-transmission: tx_en drops immediately; the in-flight request is lost; memory keeps its contents, except that a write in the reset cycle is not performed.
- Back-to-back requests: a new command is accepted in the first IDLE cycle after the final tx_done.

Test Plan:
- Write 01,05,12,34 -> one tx_en with tx_data=AA; read 03,05 -> tx bytes 12 then 34, each tx_en waiting for the prior tx_done.
- Read 03,FF with DEPTH=16 after write 01,0F,BE,EF -> replies BE,EF (wrap); busy high from the first rx_done until the final tx_done.
- Command byte 7E -> err pulse for one cycle, busy stays 0, no tx_en; next request 03,05 served normally.
- 01,05,99 then silence for TIMEOUT cycles -> err pulse, return to IDLE; later read 03,05 still returns 12,34 (no write).
- rx_done of 55 while in WAIT_HI during a read -> err pulse, lo byte still sent, 55 ignored.
- Assert reset low while in WAIT_HI -> tx_en=0, busy=0 asynchronously; after release, read 03,05 returns stored 12,34.

Source files
------------

// File: rtl/uart_instr_responder.sv
// uart_instr_responder: host-side instruction memory serving byte-level read/write requests over a UART handshake
// Ports:
//   clk, reset (async, active-low)  - clock and reset
//   rx_done, rx_data                - received byte strobe and value
//   tx_done                         - previous transmit byte finished
//   tx_en, tx_data                  - transmit start strobe and byte (tx_data held until tx_done)
//   busy                            - request in progress
//   err                             - one-cycle pulse on bad command, timeout or byte while transmitting
module uart_instr_responder #(
   parameter int         DEPTH    = 256,
   parameter int         TIMEOUT  = 1000000,
   parameter logic [7:0] ACK_BYTE = 8'hAA
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done,
   input  logic [7:0] rx_data,
   input  logic       tx_done,
   output logic       tx_en,
   output logic [7:0] tx_data,
   output logic       busy,
   output logic       err
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   typedef enum logic [3:0] {
      IDLE, GET_ADDR, GET_HI, GET_LO, WRITE, READ,
      SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, SEND_ACK, WAIT_ACK
   } state_t;
   state_t          state_q, state_d;
   logic            rd_q, rd_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [7:0]      hi_q, hi_d, lo_q, lo_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            tx_en_q, tx_en_d, err_q, err_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [15:0]     mem [DEPTH];
   logic            get_st, timeout;
   assign get_st  = state_q inside {GET_ADDR, GET_HI, GET_LO};
   // a byte landing in the final allowed cycle still counts as on time
   assign timeout = get_st && !rx_done && cnt_q == CW'(TIMEOUT - 1);
   always_comb begin
      state_d   = state_q;
      rd_d      = rd_q;
      addr_d    = addr_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      tx_data_d = tx_data_q;
      tx_en_d   = 1'b0;
      err_d     = 1'b0;
      cnt_d     = (get_st && !rx_done) ? cnt_q + CW'(1) : '0;
      if (timeout) begin
         state_d = IDLE;
         err_d   = 1'b1;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: if (rx_done) begin
               rd_d    = rx_data == 8'h03;
               state_d = (rx_data == 8'h03 || rx_data == 8'h01) ? GET_ADDR : IDLE;
               err_d   = rx_data != 8'h03 && rx_data != 8'h01;
            end
            GET_ADDR: if (rx_done) begin
               addr_d  = rx_data[AW-1:0];
               state_d = rd_q ? READ : GET_HI;
            end
            GET_HI: if (rx_done) begin
               hi_d    = rx_data;
               state_d = GET_LO;
            end
            GET_LO: if (rx_done) begin
               lo_d    = rx_data;
               state_d = WRITE;
            end
            WRITE: begin
               tx_en_d   = 1'b1;
               tx_data_d = ACK_BYTE;
               state_d   = SEND_ACK;
            end
            READ: begin
               hi_d      = mem[addr_q][15:8];
               lo_d      = mem[addr_q][7:0];
               tx_en_d   = 1'b1;
               tx_data_d = mem[addr_q][15:8];
               state_d   = SEND_HI;
            end
            SEND_HI: state_d = WAIT_HI;
            WAIT_HI: if (tx_done) begin
               tx_en_d   = 1'b1;
               tx_data_d = lo_q;
               state_d   = SEND_LO;
            end
            SEND_LO:  state_d = WAIT_LO;
            WAIT_LO:  state_d = tx_done ? IDLE : WAIT_LO;
            SEND_ACK: state_d = WAIT_ACK;
            WAIT_ACK: state_d = tx_done ? IDLE : WAIT_ACK;
            default:  state_d = IDLE;
         endcase
         // bytes arriving while a reply is pending are dropped and flagged
         if (rx_done && state_q != IDLE && !get_st) err_d = 1'b1;
      end
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         rd_q      <= 1'b0;
         addr_q    <= '0;
         hi_q      <= 8'h00;
         lo_q      <= 8'h00;
         tx_data_q <= 8'h00;
         tx_en_q   <= 1'b0;
         err_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         rd_q      <= rd_d;
         addr_q    <= addr_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         tx_data_q <= tx_data_d;
         tx_en_q   <= tx_en_d;
         err_q     <= err_d;
         cnt_q     <= cnt_d;
      end
   end
   // state is cleared asynchronously, so WRITE is never seen while reset is held
   always_ff @(posedge clk) begin
      if (state_q == WRITE) mem[addr_q] <= {hi_q, lo_q};
   end
   assign tx_en   = tx_en_q;
   assign tx_data = tx_data_q;
   assign busy    = state_q != IDLE;
   assign err     = err_q;
endmodule

// File: tb/tb_uart_instr_responder.sv
// tb_uart_instr_responder: directed and random request sequences checked against a word-array model
module tb_uart_instr_responder;
   localparam int DEPTH = 16;
   localparam int TIMEOUT = 64;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rx_done = 1'b0;
   logic [7:0] rx_data = 8'h00;
   logic       tx_done = 1'b0;
   logic       tx_en;
   logic [7:0] tx_data;
   logic       busy;
   logic       err;
   int         checks = 0;
   int         failures = 0;
   logic [15:0] mem_m [DEPTH];
   uart_instr_responder #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .ACK_BYTE(8'hAA)) dut (
      .clk(clk), .reset(reset), .rx_done(rx_done), .rx_data(rx_data),
      .tx_done(tx_done), .tx_en(tx_en), .tx_data(tx_data), .busy(busy), .err(err)
   );
   always #5 clk = ~clk;
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic send_byte(input logic [7:0] b, input int gap, input logic exp_err);
      rx_data = b;
      rx_done = 1'b1;
      tick;
      rx_done = 1'b0;
      chk("rx_err", err, exp_err);
      repeat (gap) tick;
   endtask
   task automatic wait_tx(output int lat);
      lat = 0;
      while (!tx_en && lat < 20) begin
         tick;
         lat++;
      end
      chk("tx_en_seen", tx_en, 1'b1);
   endtask
   // mode 1: stray byte during the wait; mode 2: stray byte together with tx_done
   task automatic serve(input logic [7:0] exp, input int exp_lat, input int mode);
      int lat;
      wait_tx(lat);
      chk("tx_latency", lat, exp_lat);
      chk("tx_data", tx_data, exp);
      tick;
      chk("tx_en_pulse", tx_en, 1'b0);
      if (mode == 1) begin
         rx_data = 8'h55;
         rx_done = 1'b1;
         tick;
         rx_done = 1'b0;
         chk("err_byte_in_wait", err, 1'b1);
      end
      repeat ($urandom_range(0, 4)) begin
         tick;
         chk("tx_hold_en", tx_en, 1'b0);
      end
      chk("tx_hold_data", tx_data, exp);
      tx_done = 1'b1;
      if (mode == 2) begin
         rx_data = 8'($urandom);
         rx_done = 1'b1;
      end
      tick;
      tx_done = 1'b0;
      rx_done = 1'b0;
      chk("err_after_tx_done", err, mode == 2);
   endtask
   task automatic do_write(input logic [7:0] a, input logic [15:0] d, input int gap);
      send_byte(8'h01, $urandom_range(0, 2), 1'b0);
      chk("busy_after_cmd", busy, 1'b1);
      send_byte(a, gap, 1'b0);
      send_byte(d[15:8], gap, 1'b0);
      send_byte(d[7:0], 0, 1'b0);
      mem_m[a % DEPTH] = d;
      serve(8'hAA, 1, 0);
      chk("busy_end_write", busy, 1'b0);
   endtask
   task automatic do_read(input logic [7:0] a, input int m1, input int m2);
      logic [15:0] e;
      e = mem_m[a % DEPTH];
      send_byte(8'h03, $urandom_range(0, 2), 1'b0);
      chk("busy_after_cmd", busy, 1'b1);
      send_byte(a, 0, 1'b0);
      serve(e[15:8], 1, m1);
      serve(e[7:0], 0, m2);
      chk("busy_end_read", busy, 1'b0);
   endtask
   initial begin
      int n;
      logic [7:0] b;
      repeat (3) tick;
      chk("rst_tx_en", tx_en, 1'b0);
      chk("rst_tx_data", tx_data, 8'h00);
      chk("rst_busy", busy, 1'b0);
      chk("rst_err", err, 1'b0);
      reset = 1'b1;
      tick;
      for (int a = 0; a < DEPTH; a++) do_write(8'(a), 16'($urandom), 0);
      do_write(8'h05, 16'h1234, 0);
      do_read(8'h05, 0, 0);
      do_write(8'h0F, 16'hBEEF, 1);
      do_read(8'hFF, 0, 0);
      do_read(8'h15, 0, 0);
      send_byte(8'h7E, 0, 1'b1);
      chk("badcmd_busy", busy, 1'b0);
      tick;
      chk("badcmd_err_one_cycle", err, 1'b0);
      repeat (3) begin
         tick;
         chk("badcmd_no_tx", tx_en, 1'b0);
      end
      do_read(8'h05, 0, 0);
      do_write(8'h09, 16'hA5C3, TIMEOUT - 1);
      do_read(8'h09, 0, 0);
      send_byte(8'h01, 0, 1'b0);
      send_byte(8'h05, 0, 1'b0);
      send_byte(8'h99, 0, 1'b0);
      n = 0;
      while (!err && n < TIMEOUT + 10) begin
         tick;
         n++;
      end
      chk("timeout_cycles", n, TIMEOUT);
      chk("timeout_busy", busy, 1'b0);
      tick;
      chk("timeout_err_one_cycle", err, 1'b0);
      do_read(8'h05, 0, 0);
      do_read(8'h05, 1, 0);
      do_read(8'h05, 0, 2);
      do_read(8'h05, 0, 0);
      send_byte(8'h03, 0, 1'b0);
      send_byte(8'h05, 0, 1'b0);
      wait_tx(n);
      tick;
      #2 reset = 1'b0;
      #1;
      chk("async_rst_tx_en", tx_en, 1'b0);
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_tx_data", tx_data, 8'h00);
      tick;
      tick;
      reset = 1'b1;
      tick;
      chk("post_rst_busy", busy, 1'b0);
      do_read(8'h05, 0, 0);
      for (int i = 0; i < 40; i++) begin
         n = $urandom_range(0, 9);
         if (n < 4) do_write(8'($urandom), 16'($urandom), $urandom_range(0, 3));
         else if (n < 8) do_read(8'($urandom), $urandom_range(0, 1), 2 * $urandom_range(0, 1));
         else begin
            b = 8'($urandom);
            if (b == 8'h01 || b == 8'h03) b = 8'h7E;
            send_byte(b, 0, 1'b1);
            chk("rand_badcmd_busy", busy, 1'b0);
         end
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
